// File: rtl/sd_bd_fifo_if.sv
// Host/data-master bundle for one direction of the SD buffer-descriptor store.
// master = the side that writes, reads and releases descriptors; slave = the store.
interface sd_bd_fifo_if #(
  parameter int RAM_MEM_WIDTH = 32,
  parameter int BD_WIDTH      = 5
);
  logic                     we_m;
  logic [RAM_MEM_WIDTH-1:0] dat_in_m;
  logic [BD_WIDTH-1:0]      free_bd;
  logic                     wr_ovf;
  logic                     re_s;
  logic                     ack_o_s;
  logic [RAM_MEM_WIDTH-1:0] dat_out_s;
  logic                     a_cmp;

  modport master (
    output we_m, dat_in_m, re_s, a_cmp,
    input  free_bd, wr_ovf, ack_o_s, dat_out_s
  );

  modport slave (
    input  we_m, dat_in_m, re_s, a_cmp,
    output free_bd, wr_ovf, ack_o_s, dat_out_s
  );
endinterface

// File: rtl/sd_bd_fifo.sv
// Circular two-word descriptor store: host writes (address, argument) pairs,
// data master reads words over a req/ack handshake and releases slots on a_cmp.
module sd_bd_fifo #(
  parameter int RAM_MEM_WIDTH = 32,
  parameter int BD_SIZE       = 16,
  parameter int BD_WIDTH      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  sd_bd_fifo_if.slave   bus
);

  localparam int AW  = $clog2(BD_SIZE);
  localparam int AVW = AW + 1;
  localparam logic [BD_WIDTH-1:0] BD_EMPTY = BD_WIDTH'(BD_SIZE / 2);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_ACK  = 2'd2;

  logic [RAM_MEM_WIDTH-1:0] ram [BD_SIZE];

  logic [AW-1:0]            wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q,  rd_ptr_d;
  logic                     phase_q,   phase_d;
  logic [AVW-1:0]           avail_q,   avail_d;
  logic [BD_WIDTH-1:0]      free_bd_q, free_bd_d;
  logic                     wr_ovf_q,  wr_ovf_d;
  logic                     ack_q,     ack_d;
  logic [RAM_MEM_WIDTH-1:0] dat_out_q, dat_out_d;
  logic [1:0]               state_q,   state_d;
  logic                     a_cmp_q,   a_cmp_d;

  logic wr_accept;
  logic wr_en;
  logic commit;
  logic rel_ok;
  logic rd_take;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    phase_d   = phase_q;
    avail_d   = avail_q;
    free_bd_d = free_bd_q;
    wr_ovf_d  = wr_ovf_q;
    ack_d     = 1'b0;
    dat_out_d = dat_out_q;
    state_d   = state_q;
    a_cmp_d   = bus.a_cmp;

    wr_accept = bus.we_m && (free_bd_q != '0);
    commit    = wr_accept && phase_q;
    rel_ok    = bus.a_cmp && !a_cmp_q && (free_bd_q != BD_EMPTY);
    rd_take   = (state_q == R_READ);

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      phase_d  = ~phase_q;
    end
    if (bus.we_m && !wr_accept) wr_ovf_d = 1'b1;

    // A commit and a release in the same cycle cancel out.
    unique case ({commit, rel_ok})
      2'b10:   free_bd_d = free_bd_q - BD_WIDTH'(1);
      2'b01:   free_bd_d = free_bd_q + BD_WIDTH'(1);
      default: free_bd_d = free_bd_q;
    endcase

    avail_d = avail_q + (commit ? AVW'(2) : '0) - (rd_take ? AVW'(1) : '0);

    case (state_q)
      R_IDLE: if (bus.re_s && (avail_q != '0)) state_d = R_READ;
      R_READ: begin
        dat_out_d = ram[rd_ptr_q];
        ack_d     = 1'b1;
        rd_ptr_d  = rd_ptr_q + AW'(1);
        state_d   = R_ACK;
      end
      R_ACK:   state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase

    // Synchronous flush wins over every other input, including a pending write.
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      phase_d   = 1'b0;
      avail_d   = '0;
      free_bd_d = BD_EMPTY;
      wr_ovf_d  = 1'b0;
      ack_d     = 1'b0;
      dat_out_d = '0;
      state_d   = R_IDLE;
      a_cmp_d   = 1'b0;
    end

    wr_en = wr_accept && !clr;
  end

  // NOTE: the descriptor RAM is deliberately not reset; pointers and avail guard every stale word.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr_q] <= bus.dat_in_m;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      phase_q   <= 1'b0;
      avail_q   <= '0;
      free_bd_q <= BD_EMPTY;
      wr_ovf_q  <= 1'b0;
      ack_q     <= 1'b0;
      dat_out_q <= '0;
      state_q   <= R_IDLE;
      a_cmp_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      phase_q   <= phase_d;
      avail_q   <= avail_d;
      free_bd_q <= free_bd_d;
      wr_ovf_q  <= wr_ovf_d;
      ack_q     <= ack_d;
      dat_out_q <= dat_out_d;
      state_q   <= state_d;
      a_cmp_q   <= a_cmp_d;
    end
  end

  assign bus.free_bd   = free_bd_q;
  assign bus.wr_ovf    = wr_ovf_q;
  assign bus.ack_o_s   = ack_q;
  assign bus.dat_out_s = dat_out_q;

endmodule
